dps_req_bridge: RTL and testbench

- CPU-side request bridge sitting directly upstream of the default peripheral system (DPS) request port.
- Buffers CPU load/store requests in a small FIFO and issues them one at a time under the DPS busy handshake.
- Tracks the single outstanding read and returns its data to the CPU.
- Adds address-range checking and a read timeout so a missing DPS response cannot hang the CPU.

---
 rtl/dps_bridge_pkg.sv | 34 +++
 rtl/dps_req_bridge_if.sv | 34 +++
 rtl/dps_bridge_fifo.sv | 55 +++++
 rtl/dps_req_bridge.sv | 155 +++++++++++++++
 tb/tb_dps_req_bridge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dps_bridge_pkg.sv
// Shared types and constants for the CPU-to-DPS request bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, request FIFO entry layout, error data word,
// counter width and the address legality check applied at accept.
package dps_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'h0,
    RD_WAIT = 2'h1,
    DRAIN   = 2'h2
  } state_t;

  localparam int RW_W    = 1;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = RW_W + ADDR_W + DATA_W;
  localparam int CNT_W   = 16;

  localparam logic [DATA_W-1:0] DPS_ERR_DATA = 32'hFFFF_FFFF;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Out of range or not word aligned.
  function automatic logic addr_illegal(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] limit);
    return (addr >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dps_req_bridge_if.sv
// Bundles the CPU-side and DPS-side signals of the request bridge.
// Latency: n/a (wiring only).
// Backpressure: oCPU_BUSY toward the CPU, iDPS_BUSY from the DPS.
// Modports: slave = the bridge itself, master = the CPU/DPS environment.
interface dps_req_bridge_if;
  import dps_bridge_pkg::*;

  logic              iCPU_REQ;
  logic              oCPU_BUSY;
  logic              iCPU_RW;
  logic [ADDR_W-1:0] iCPU_ADDR;
  logic [DATA_W-1:0] iCPU_DATA;
  logic              oCPU_VALID;
  logic [DATA_W-1:0] oCPU_DATA;
  logic              oCPU_ERR;
  logic              oDPS_REQ;
  logic              iDPS_BUSY;
  logic              oDPS_RW;
  logic [ADDR_W-1:0] oDPS_ADDR;
  logic [DATA_W-1:0] oDPS_DATA;
  logic              iDPS_VALID;
  logic [DATA_W-1:0] iDPS_DATA;

  modport slave (
    input  iCPU_REQ, iCPU_RW, iCPU_ADDR, iCPU_DATA, iDPS_BUSY, iDPS_VALID, iDPS_DATA,
    output oCPU_BUSY, oCPU_VALID, oCPU_DATA, oCPU_ERR, oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA
  );

  modport master (
    output iCPU_REQ, iCPU_RW, iCPU_ADDR, iCPU_DATA, iDPS_BUSY, iDPS_VALID, iDPS_DATA,
    input  oCPU_BUSY, oCPU_VALID, oCPU_DATA, oCPU_ERR, oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA
  );

endinterface

// File: rtl/dps_bridge_fifo.sv
// Synchronous FIFO holding queued DPS requests, head visible combinationally.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: full blocks push, empty blocks pop; push+pop in one cycle keeps count.
// Ports: iCLOCK/inRESET, push/push_dat, pop, full/empty, head_dat.
module dps_bridge_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // Storage is cleared too so the forwarded head reads as zero after reset.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dps_req_bridge.sv
// CPU-to-DPS request bridge: range check, request FIFO, one outstanding read, read timeout.
// Latency: read data reaches the CPU DPS latency + 2 cycles after accept into an empty FIFO.
// Backpressure: oCPU_BUSY while the FIFO is full; issue stalls while iDPS_BUSY is high.
// Ports: iCLOCK, inRESET (async, active-low), bus (dps_req_bridge_if.slave, CPU and DPS sides).
module dps_req_bridge
  import dps_bridge_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int          RD_TIMEOUT = 255,
  parameter logic [31:0] ADDR_LIMIT = 32'h200
) (
  input  logic            iCLOCK,
  input  logic            inRESET,
  dps_req_bridge_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RD_TIMEOUT - 1);

  entry_t            push_ent;
  entry_t            head_ent;
  logic              full;
  logic              empty;
  logic              accept;
  logic              bad;
  logic              push;
  logic              pop;
  logic              rej;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Response produced by the FSM this cycle (DPS data or timeout error).
  logic              rsp_vld;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_dat;

  // One-deep parking slot for a response displaced by a reject return.
  logic              hold_vld;
  logic              hold_err;
  logic [DATA_W-1:0] hold_dat;

  assign accept = bus.iCPU_REQ && !full;
  assign bad    = addr_illegal(bus.iCPU_ADDR, ADDR_LIMIT);
  assign push   = accept && !bad;
  assign rej    = accept && bad;

  assign push_ent = '{rw: bus.iCPU_RW, addr: bus.iCPU_ADDR, data: bus.iCPU_DATA};

  dps_bridge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_dat (head_ent)
  );

  assign bus.oCPU_BUSY = full;
  assign bus.oDPS_REQ  = pop;
  assign bus.oDPS_RW   = head_ent.rw;
  assign bus.oDPS_ADDR = head_ent.addr;
  assign bus.oDPS_DATA = head_ent.data;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    rsp_vld   = 1'b0;
    rsp_err   = 1'b0;
    rsp_dat   = bus.iDPS_DATA;
    case (state)
      IDLE: begin
        // A parked response must drain before another read can be issued,
        // so the parking slot can never be asked to hold two responses.
        pop = !empty && !bus.iDPS_BUSY && !hold_vld;
        if (pop && !head_ent.rw) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = '0;
        end
      end
      RD_WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (bus.iDPS_VALID) begin
          rsp_vld   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == TMO_LAST) begin
          rsp_vld   = 1'b1;
          rsp_err   = 1'b1;
          rsp_dat   = DPS_ERR_DATA;
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        // Late response is swallowed; it only ends the drain early.
        cnt_nxt = cnt + 1'b1;
        if (bus.iDPS_VALID || (cnt == TMO_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reject returns take the return slot; a colliding FSM response is
  // parked and sent on the next free cycle.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      bus.oCPU_VALID <= 1'b0;
      bus.oCPU_ERR   <= 1'b0;
      bus.oCPU_DATA  <= '0;
      hold_vld       <= 1'b0;
      hold_err       <= 1'b0;
      hold_dat       <= '0;
    end else begin
      bus.oCPU_VALID <= 1'b0;
      bus.oCPU_ERR   <= 1'b0;
      if (rej) begin
        bus.oCPU_VALID <= !bus.iCPU_RW;
        bus.oCPU_ERR   <= 1'b1;
        if (!bus.iCPU_RW) bus.oCPU_DATA <= DPS_ERR_DATA;
        if (rsp_vld) begin
          hold_vld <= 1'b1;
          hold_err <= rsp_err;
          hold_dat <= rsp_dat;
        end
      end else if (hold_vld) begin
        bus.oCPU_VALID <= 1'b1;
        bus.oCPU_ERR   <= hold_err;
        bus.oCPU_DATA  <= hold_dat;
        hold_vld       <= 1'b0;
      end else if (rsp_vld) begin
        bus.oCPU_VALID <= 1'b1;
        bus.oCPU_ERR   <= rsp_err;
        bus.oCPU_DATA  <= rsp_dat;
      end
    end
  end

endmodule

// File: tb/tb_dps_req_bridge.sv
// Directed bench for dps_req_bridge with RD_TIMEOUT = 8, FIFO_DEPTH = 4, ADDR_LIMIT = 0x200.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: iDPS_BUSY driven directly by the stimulus sequence.
module tb_dps_req_bridge;

  logic iCLOCK;
  logic inRESET;
  int   n_chk;
  int   n_pass;
  int   req_cnt;
  int   vld_cnt;
  int   base;

  dps_req_bridge_if bus ();

  dps_req_bridge #(
    .FIFO_DEPTH (4),
    .RD_TIMEOUT (8),
    .ADDR_LIMIT (32'h200)
  ) dut (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .bus     (bus)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Running counts of DPS issues and CPU return pulses, sampled mid-cycle.
  initial begin
    req_cnt = 0;
    vld_cnt = 0;
  end
  always @(negedge iCLOCK) begin
    if (bus.oDPS_REQ === 1'b1)   req_cnt = req_cnt + 1;
    if (bus.oCPU_VALID === 1'b1) vld_cnt = vld_cnt + 1;
  end

  task automatic nxt();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic mid();
    @(negedge iCLOCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cpu(input logic req, input logic rw, input logic [31:0] addr,
                     input logic [31:0] data);
    bus.iCPU_REQ  = req;
    bus.iCPU_RW   = rw;
    bus.iCPU_ADDR = addr;
    bus.iCPU_DATA = data;
  endtask

  task automatic ret(input logic vld, input logic [31:0] data);
    bus.iDPS_VALID = vld;
    bus.iDPS_DATA  = data;
  endtask

  task automatic rsp(input string tag, input logic vld, input logic err,
                     input logic [31:0] data);
    chk({tag, "_vld"}, {31'd0, bus.oCPU_VALID}, {31'd0, vld});
    chk({tag, "_err"}, {31'd0, bus.oCPU_ERR}, {31'd0, err});
    if (vld) chk({tag, "_dat"}, bus.oCPU_DATA, data);
  endtask

  task automatic iss(input string tag, input logic req, input logic rw,
                     input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, bus.oDPS_REQ}, {31'd0, req});
    if (req) begin
      chk({tag, "_rw"}, {31'd0, bus.oDPS_RW}, {31'd0, rw});
      chk({tag, "_addr"}, bus.oDPS_ADDR, addr);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    base   = 0;
    inRESET = 1'b0;
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    ret(1'b0, 32'h0);
    bus.iDPS_BUSY = 1'b0;

    // Reset state
    nxt(); mid();
    rsp("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_data", bus.oCPU_DATA, 32'h0);
    chk("rst_busy", {31'd0, bus.oCPU_BUSY}, 32'd0);
    iss("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_daddr", bus.oDPS_ADDR, 32'h0);
    nxt(); inRESET = 1'b1;
    nxt(); nxt();

    // Read 0x100, DPS answers 3 cycles after issue
    base = req_cnt;
    cpu(1'b1, 1'b0, 32'h100, 32'h0); mid();
    chk("rd_accept", {31'd0, bus.oCPU_BUSY}, 32'd0);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); mid();
    iss("rd_issue", 1'b1, 1'b0, 32'h100);
    nxt(); mid(); rsp("rd_w1", 1'b0, 1'b0, 32'h0);
    nxt(); mid(); rsp("rd_w2", 1'b0, 1'b0, 32'h0);
    nxt(); ret(1'b1, 32'h1234ABCD); mid();
    rsp("rd_w3", 1'b0, 1'b0, 32'h0);
    nxt(); ret(1'b0, 32'h0); mid();
    rsp("rd_ret", 1'b1, 1'b0, 32'h1234ABCD);
    nxt(); mid(); rsp("rd_after", 1'b0, 1'b0, 32'h0);
    chk("rd_one_req", req_cnt - base, 32'd1);
    nxt(); nxt();

    // Five writes while DPS busy; FIFO fills after four
    bus.iDPS_BUSY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu(1'b1, 1'b1, 32'(i * 4), 32'hA0 + 32'(i)); mid();
      chk("wr_fill_busy", {31'd0, bus.oCPU_BUSY}, 32'd0);
      iss("wr_fill", 1'b0, 1'b0, 32'h0);
      nxt();
    end
    cpu(1'b1, 1'b1, 32'h10, 32'hA4); mid();
    chk("wr_full_busy", {31'd0, bus.oCPU_BUSY}, 32'd1);
    nxt(); bus.iDPS_BUSY = 1'b0; mid();
    chk("wr_pop0_busy", {31'd0, bus.oCPU_BUSY}, 32'd1);
    iss("wr_pop0", 1'b1, 1'b1, 32'h0);
    chk("wr_pop0_dat", bus.oDPS_DATA, 32'hA0);
    nxt(); mid();
    chk("wr_fifth_acc", {31'd0, bus.oCPU_BUSY}, 32'd0);
    iss("wr_pop1", 1'b1, 1'b1, 32'h4);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); mid(); iss("wr_pop2", 1'b1, 1'b1, 32'h8);
    nxt(); mid(); iss("wr_pop3", 1'b1, 1'b1, 32'hC);
    nxt(); mid(); iss("wr_pop4", 1'b1, 1'b1, 32'h10);
    chk("wr_pop4_dat", bus.oDPS_DATA, 32'hA4);
    nxt(); mid(); iss("wr_empty", 1'b0, 1'b0, 32'h0);
    nxt();

    // Rejected requests
    base = req_cnt;
    cpu(1'b1, 1'b0, 32'h200, 32'h0); mid();
    nxt(); cpu(1'b1, 1'b0, 32'h102, 32'h0); mid();
    rsp("rej_range", 1'b1, 1'b1, 32'hFFFFFFFF);
    nxt(); cpu(1'b1, 1'b1, 32'h300, 32'h5); mid();
    rsp("rej_align", 1'b1, 1'b1, 32'hFFFFFFFF);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); mid();
    rsp("rej_write", 1'b0, 1'b1, 32'h0);
    nxt(); mid();
    rsp("rej_quiet", 1'b0, 1'b0, 32'h0);
    chk("rej_no_req", req_cnt - base, 32'd0);
    nxt();

    // Read timeout with a write queued behind it
    cpu(1'b1, 1'b0, 32'h7C, 32'h0); mid();
    nxt(); cpu(1'b1, 1'b1, 32'h40, 32'h55); mid();
    iss("to_issue", 1'b1, 1'b0, 32'h7C);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); mid();
    iss("to_wait", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) begin nxt(); mid(); end
    rsp("to_pre", 1'b0, 1'b0, 32'h0);
    nxt(); mid();
    rsp("to_err", 1'b1, 1'b1, 32'hFFFFFFFF);
    nxt(); mid(); iss("to_drain1", 1'b0, 1'b0, 32'h0);
    nxt(); ret(1'b1, 32'hDEAD0000); mid();
    iss("to_drain2", 1'b0, 1'b0, 32'h0);
    nxt(); ret(1'b0, 32'h0); mid();
    rsp("to_late", 1'b0, 1'b0, 32'h0);
    iss("to_wr_issue", 1'b1, 1'b1, 32'h40);
    nxt(); mid(); rsp("to_late2", 1'b0, 1'b0, 32'h0);
    nxt();

    // Write then read queued under busy: issue order and single return
    base = vld_cnt;
    bus.iDPS_BUSY = 1'b1;
    cpu(1'b1, 1'b1, 32'h4, 32'h77);
    nxt(); cpu(1'b1, 1'b0, 32'h7C, 32'h0);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); bus.iDPS_BUSY = 1'b0; mid();
    iss("ord_wr", 1'b1, 1'b1, 32'h4);
    nxt(); mid(); iss("ord_rd", 1'b1, 1'b0, 32'h7C);
    nxt(); ret(1'b1, 32'hCAFEF00D); mid(); iss("ord_wait", 1'b0, 1'b0, 32'h0);
    nxt(); ret(1'b0, 32'h0); mid();
    rsp("ord_ret", 1'b1, 1'b0, 32'hCAFEF00D);
    nxt(); nxt(); mid();
    chk("ord_once", vld_cnt - base, 32'd1);
    nxt();

    // Reject return colliding with a DPS response: DPS data one cycle later
    cpu(1'b1, 1'b0, 32'h100, 32'h0);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); mid();
    iss("col_issue", 1'b1, 1'b0, 32'h100);
    nxt(); cpu(1'b1, 1'b0, 32'h204, 32'h0); ret(1'b1, 32'h0BADBEEF);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); ret(1'b0, 32'h0); mid();
    rsp("col_rej", 1'b1, 1'b1, 32'hFFFFFFFF);
    nxt(); mid(); rsp("col_dps", 1'b1, 1'b0, 32'h0BADBEEF);
    nxt(); mid(); rsp("col_done", 1'b0, 1'b0, 32'h0);
    nxt();

    // Reset during RD_WAIT with two writes queued
    bus.iDPS_BUSY = 1'b1;
    cpu(1'b1, 1'b0, 32'h100, 32'h0);
    nxt(); cpu(1'b1, 1'b1, 32'h8, 32'h1);
    nxt(); cpu(1'b1, 1'b1, 32'hC, 32'h2);
    nxt(); cpu(1'b0, 1'b0, 32'h0, 32'h0); bus.iDPS_BUSY = 1'b0; mid();
    iss("mr_issue", 1'b1, 1'b0, 32'h100);
    nxt(); inRESET = 1'b0; mid();
    base = vld_cnt;
    rsp("mr_rst", 1'b0, 1'b0, 32'h0);
    chk("mr_data", bus.oCPU_DATA, 32'h0);
    chk("mr_busy", {31'd0, bus.oCPU_BUSY}, 32'd0);
    iss("mr_rst", 1'b0, 1'b0, 32'h0);
    chk("mr_daddr", bus.oDPS_ADDR, 32'h0);
    chk("mr_ddata", bus.oDPS_DATA, 32'h0);
    chk("mr_drw", {31'd0, bus.oDPS_RW}, 32'd0);
    nxt(); inRESET = 1'b1; ret(1'b1, 32'h999); mid();
    iss("mr_empty0", 1'b0, 1'b0, 32'h0);
    nxt(); ret(1'b0, 32'h0); mid();
    iss("mr_empty1", 1'b0, 1'b0, 32'h0);
    nxt(); nxt(); mid();
    chk("mr_no_rsp", vld_cnt - base, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
